// File: rtl/maze_job_scheduler.sv
// maze_job_scheduler: round-robin arbiter that feeds one requester's maze to a shared solver and relays its answer
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req, req_valid, req_maze   per-requester job request, maze-bit valid and maze bit
//   gnt                        one-hot grant held for the whole job
//   sol_rst_n, sol_in_valid,
//   sol_maze                   solver reset and maze-bit feed
//   sol_out_valid,
//   sol_not_valid, sol_x/y     solver path coordinate stream and no-path pulse
//   rsp_valid, rsp_x/y, rsp_id registered coordinate response and its owner
//   done, stat                 job-complete pulse and status (00 path, 01 no path, 10 load gap, 11 timeout)
module maze_job_scheduler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_maze,
    output logic [1:0] gnt,
    output logic       sol_rst_n,
    output logic       sol_in_valid,
    output logic       sol_maze,
    input  logic       sol_out_valid,
    input  logic       sol_not_valid,
    input  logic [3:0] sol_x,
    input  logic [3:0] sol_y,
    output logic       rsp_valid,
    output logic [3:0] rsp_x,
    output logic [3:0] rsp_y,
    output logic       rsp_id,
    output logic       done,
    output logic [1:0] stat
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, STREAM, ABORT, DONE} state_t;
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [11:0] tmr_q;
    logic        id_q, ptr_q, pick_d, rsp_valid_d;
    logic [1:0]  gnt_q, stat_q;
    logic        rsp_valid_q, done_q;
    logic [3:0]  rsp_x_q, rsp_y_q;
    // ptr_q names the requester that wins a tie
    assign pick_d       = req[ptr_q] ? ptr_q : ~ptr_q;
    // the coordinate that moves WAIT into STREAM is itself part of the path
    assign rsp_valid_d  = sol_out_valid && ((state_q == WAIT && !sol_not_valid) || state_q == STREAM);
    assign sol_in_valid = (state_q == LOAD) && req_valid[id_q];
    assign sol_maze     = (state_q == LOAD) && req_maze[id_q];
    assign sol_rst_n    = rst_n && (state_q != ABORT);
    assign gnt          = gnt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_x        = rsp_x_q;
    assign rsp_y        = rsp_y_q;
    assign rsp_id       = id_q;
    assign done         = done_q;
    assign stat         = stat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            tmr_q       <= 12'd0;
            id_q        <= 1'b0;
            ptr_q       <= 1'b0;
            gnt_q       <= 2'b00;
            stat_q      <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_x_q     <= 4'd0;
            rsp_y_q     <= 4'd0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            rsp_valid_q <= rsp_valid_d;
            if (rsp_valid_d) begin
                rsp_x_q <= sol_x;
                rsp_y_q <= sol_y;
            end
            case (state_q)
                IDLE: if (|req) begin
                    id_q    <= pick_d;
                    gnt_q   <= {pick_d, ~pick_d};
                    cnt_q   <= 8'd0;
                    state_q <= LOAD;
                end
                LOAD: if (req_valid[id_q]) begin
                    if (cnt_q == 8'd224) begin
                        cnt_q   <= 8'd0;
                        tmr_q   <= 12'd0;
                        state_q <= WAIT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end else if (cnt_q != 8'd0) begin
                    // a gap is only legal before the first beat
                    stat_q  <= 2'b10;
                    cnt_q   <= 8'd0;
                    state_q <= ABORT;
                end
                WAIT: if (sol_not_valid) begin
                    stat_q  <= 2'b01;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end else if (sol_out_valid) begin
                    state_q <= STREAM;
                end else if (tmr_q == 12'd2999) begin
                    stat_q  <= 2'b11;
                    cnt_q   <= 8'd0;
                    state_q <= ABORT;
                end else begin
                    tmr_q <= tmr_q + 12'd1;
                end
                STREAM: if (!sol_out_valid) begin
                    stat_q  <= 2'b00;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                ABORT: if (cnt_q[0]) begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                DONE: begin
                    gnt_q   <= 2'b00;
                    ptr_q   <= ~id_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_job_scheduler.sv
// tb_maze_job_scheduler: randomized scoreboard bench for maze_job_scheduler, the bench plays both requesters and the solver
module tb_maze_job_scheduler;
    localparam int M_PATH = 0, M_NV = 1, M_BOTH = 2, M_GAP = 3, M_TO = 4, M_RST = 5;
    logic       clk, rst_n;
    logic [1:0] req, req_valid, req_maze, gnt, stat;
    logic       sol_rst_n, sol_in_valid, sol_maze, sol_out_valid, sol_not_valid;
    logic [3:0] sol_x, sol_y, rsp_x, rsp_y;
    logic       rsp_valid, rsp_id, done;
    typedef struct {
        bit         is_done;
        logic [3:0] x, y;
        logic       id;
        logic [1:0] st;
        int         lo, hi;
    } exp_t;
    exp_t       sbq[$];
    int         tests = 0, fails = 0, cyc = 0;
    int         nxt = 0, exp_aborts = 0, abort_runs = 0, onehot_bad = 0, lowrun = 0;
    logic [3:0] last_x = 4'd0, last_y = 4'd0;

    maze_job_scheduler dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_valid(req_valid), .req_maze(req_maze),
        .gnt(gnt), .sol_rst_n(sol_rst_n), .sol_in_valid(sol_in_valid), .sol_maze(sol_maze),
        .sol_out_valid(sol_out_valid), .sol_not_valid(sol_not_valid), .sol_x(sol_x), .sol_y(sol_y),
        .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_id(rsp_id), .done(done), .stat(stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input bit d, input logic [3:0] x, input logic [3:0] y,
                                 input int id, input logic [1:0] st, input int lo, input int hi);
        exp_t e;
        e.is_done = d; e.x = x; e.y = y; e.id = id[0]; e.st = st; e.lo = lo; e.hi = hi;
        sbq.push_back(e);
    endfunction

    task automatic pop_chk(input bit d);
        exp_t e;
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected_%s: cycle %0d x=%0d y=%0d id=%0d stat=%0d, nothing expected",
                     d ? "done" : "rsp", cyc, rsp_x, rsp_y, rsp_id, stat);
        end else begin
            e = sbq.pop_front();
            if (e.is_done != d || cyc < e.lo || cyc > e.hi || rsp_id !== e.id ||
                (d ? (stat !== e.st) : (rsp_x !== e.x || rsp_y !== e.y))) begin
                fails++;
                $display("FAIL sb_%s: got cycle %0d x=%0d y=%0d id=%0d stat=%0d; expected %s cycle %0d..%0d x=%0d y=%0d id=%0d stat=%0d",
                         d ? "done" : "rsp", cyc, rsp_x, rsp_y, rsp_id, stat,
                         e.is_done ? "done" : "rsp", e.lo, e.hi, e.x, e.y, e.id, e.st);
            end
        end
    endtask

    // monitor: scoreboard pops, grant one-hot watch, solver-reset pulse width
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt == 2'b11) onehot_bad++;
            if (rsp_valid) pop_chk(1'b0);
            if (done) pop_chk(1'b1);
            if (!sol_rst_n) lowrun++;
            else if (lowrun != 0) begin
                chk("sol_rst_n_low_cycles", lowrun, 2);
                abort_runs++;
                lowrun = 0;
            end
        end else begin
            lowrun = 0;
        end
    end

    task automatic run_job(input logic [1:0] rq, input int mode, input int arg);
        int eid, w, err, nb, ce;
        logic [1:0] g;
        eid = rq[nxt] ? nxt : 1 - nxt;
        err = 0;
        req = rq;
        w = 0;
        do begin step(); w++; end while (gnt == 2'b00 && w < 20);
        chk("grant", gnt, 2'b01 << eid);
        g = gnt;
        req = 2'($urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) begin
            req_valid = 2'($urandom); req_valid[eid] = 1'b0; req_maze = 2'($urandom);
            #1 if (sol_in_valid !== 1'b0) err++;
            step();
        end
        nb = (mode == M_GAP) ? arg : 225;
        for (int b = 0; b < nb; b++) begin
            req_valid = 2'($urandom); req_valid[eid] = 1'b1; req_maze = 2'($urandom);
            #1 if (sol_in_valid !== 1'b1 || sol_maze !== req_maze[eid] || gnt !== g) err++;
            step();
        end
        ce = cyc;
        req_valid = 2'b00;
        if (mode == M_GAP) begin
            req_valid = 2'($urandom); req_valid[eid] = 1'b0;
            push(1'b1, 4'd0, 4'd0, eid, 2'b10, ce + 3, ce + 3);
            exp_aborts++;
        end else if (mode == M_TO) begin
            push(1'b1, 4'd0, 4'd0, eid, 2'b11, ce + 3001, ce + 3003);
            exp_aborts++;
        end else begin
            repeat ($urandom_range(0, 10)) step();
            if (mode == M_NV || mode == M_BOTH) begin
                sol_not_valid = 1'b1; sol_out_valid = (mode == M_BOTH);
                sol_x = 4'($urandom); sol_y = 4'($urandom);
                push(1'b1, 4'd0, 4'd0, eid, 2'b01, cyc + 1, cyc + 1);
                step();
                sol_not_valid = 1'b0; sol_out_valid = 1'b0;
            end else begin
                for (int i = 0; i < arg; i++) begin
                    sol_out_valid = 1'b1; sol_x = 4'($urandom); sol_y = 4'($urandom);
                    push(1'b0, sol_x, sol_y, eid, 2'b00, cyc + 1, cyc + 1);
                    last_x = sol_x; last_y = sol_y;
                    if (mode == M_RST && i == 2) begin
                        #2 rst_n = 1'b0;
                        #1 chk("reset_mid_outputs", {gnt, rsp_valid, rsp_x, rsp_y, rsp_id, done, stat,
                                                     sol_in_valid, sol_maze, sol_rst_n}, 0);
                        sbq.delete();
                        nxt = 0; last_x = 4'd0; last_y = 4'd0;
                        sol_out_valid = 1'b0; req = 2'b00; req_valid = 2'b00;
                        repeat (2) step();
                        rst_n = 1'b1;
                        return;
                    end
                    step();
                end
                sol_out_valid = 1'b0; sol_x = 4'($urandom); sol_y = 4'($urandom);
                push(1'b1, 4'd0, 4'd0, eid, 2'b00, cyc + 1, cyc + 1);
            end
        end
        w = 0;
        while (done !== 1'b1 && w < 3200) begin
            #1 if (sol_in_valid !== 1'b0 || gnt !== g) err++;
            step();
            w++;
            if (done !== 1'b1) begin
                req_valid = 2'($urandom); req_maze = 2'($urandom);
                sol_x = 4'($urandom); sol_y = 4'($urandom);
            end
        end
        chk("done_seen", done, 1);
        req = 2'b00; req_valid = 2'b00; req_maze = 2'b00;
        nxt = 1 - eid;
        step();
        step();
        chk("gnt_release", gnt, 0);
        chk("sb_drain", sbq.size(), 0);
        chk("rsp_hold", {rsp_x, rsp_y}, {last_x, last_y});
        chk("load_and_hold", err, 0);
    endtask

    initial begin
        int m;
        req = 2'b00; req_valid = 2'b00; req_maze = 2'b00;
        sol_out_valid = 1'b0; sol_not_valid = 1'b0; sol_x = 4'd0; sol_y = 4'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("reset_async", {gnt, rsp_valid, rsp_x, rsp_y, rsp_id, done, stat,
                               sol_in_valid, sol_maze, sol_rst_n}, 0);
        repeat (2) step();
        chk("reset_hold", {gnt, rsp_valid, done, stat, sol_rst_n}, 0);
        rst_n = 1'b1;
        step();
        chk("sol_rst_n_release", sol_rst_n, 1);
        chk("idle_no_grant", gnt, 0);
        run_job(2'b11, M_PATH, 3);
        run_job(2'b11, M_PATH, 2);
        run_job(2'b01, M_PATH, 5);
        run_job(2'($urandom_range(1, 3)), M_GAP, 100);
        run_job(2'b10, M_GAP, 1);
        run_job(2'b01, M_GAP, 224);
        run_job(2'($urandom_range(1, 3)), M_NV, 0);
        run_job(2'($urandom_range(1, 3)), M_BOTH, 0);
        run_job(2'($urandom_range(1, 3)), M_TO, 0);
        repeat (8) begin
            m = $urandom_range(0, 3);
            run_job(2'($urandom_range(1, 3)), m, (m == M_GAP) ? $urandom_range(1, 224) : $urandom_range(1, 6));
        end
        run_job(2'b11, M_RST, 5);
        repeat (3) begin
            step();
            chk("idle_after_reset", gnt, 0);
        end
        run_job(2'b10, M_PATH, 4);
        chk("gnt_onehot_violations", onehot_bad, 0);
        chk("abort_runs", abort_runs, exp_aborts);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule

// File: doc/maze_job_scheduler.md
MAZE_JOB_SCHEDULER -- requirements
Module: maze_job_scheduler

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port req  input  2  per-requester job request, held until grant.
REQ-004 SHALL have port req_valid  input  2  per-requester maze-bit valid.
REQ-005 SHALL have port req_maze  input  2  per-requester maze bit (1 = wall).
REQ-006 SHALL have port gnt  output  2  one-hot grant, held for the whole job.
REQ-007 SHALL have port sol_rst_n  output  1  solver reset (active-low).
REQ-008 SHALL have port sol_in_valid  output  1  solver input valid.
REQ-009 SHALL have port sol_maze  output  1  solver maze bit.
REQ-010 SHALL have port sol_out_valid  input  1  solver path-coordinate valid.
REQ-011 SHALL have port sol_not_valid  input  1  solver no-path pulse.
REQ-012 SHALL have port sol_x, sol_y  input  4 each  solver path coordinate.
REQ-013 SHALL have port rsp_valid  output  1  registered copy of sol_out_valid.
REQ-014 SHALL have port rsp_x, rsp_y  output  4 each  registered coordinate.
REQ-015 SHALL have port rsp_id  output  1  requester owning the current response or done.
REQ-016 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-017 SHALL have port stat  output  2  status on done: 00 path, 01 no path, 10 load gap, 11 timeout.

Function
REQ-018 SHALL implement states IDLE, LOAD, WAIT, STREAM, ABORT, DONE.
REQ-019 IDLE: if any req bit is set, grant round-robin starting after the last-served requester (requester 0 first after reset); move to LOAD with gnt asserted on the next cycle.
REQ-020 LOAD: sol_in_valid = req_valid[id] and sol_maze = req_maze[id], combinational from the granted requester; the other requester is ignored.
REQ-021 LOAD: count valid beats 0..224 in an 8-bit counter; the beat where the count reaches 224 moves to WAIT.
REQ-022 LOAD: if req_valid[id] is low after the first beat and before beat 225, go to ABORT with stat 10.
REQ-023 WAIT: count idle cycles; sol_out_valid=1 goes to STREAM; sol_not_valid=1 goes to DONE with stat 01; a count of 3000 goes to ABORT with stat 11.
REQ-024 If sol_out_valid and sol_not_valid are both high in the same cycle, sol_not_valid SHALL win (stat 01).
REQ-025 STREAM: rsp_valid/rsp_x/rsp_y SHALL follow the solver with exactly 1 cycle latency; the first cycle with sol_out_valid=0 goes to DONE with stat 00.
REQ-026 ABORT: drive sol_rst_n low for exactly 2 cycles, then go to DONE.
REQ-027 DONE: pulse done for 1 cycle with stat and rsp_id; release gnt; update the last-served pointer; return to IDLE.
REQ-028 A new grant SHALL NOT occur in the DONE cycle; the earliest re-grant is the cycle after DONE.
REQ-029 req deassertion after grant SHALL have no effect until DONE.
REQ-030 rsp_valid SHALL be 0 outside STREAM and the cycle after it; rsp_x/rsp_y SHALL hold their last values.

Reset
REQ-031 While rst_n=0: state IDLE, gnt=0, sol_in_valid=0, sol_maze=0, rsp_valid=0, rsp_x=0, rsp_y=0, rsp_id=0, done=0, stat=0, counters=0, pointer selects requester 0.
REQ-032 sol_rst_n SHALL equal 0 while rst_n=0 (combinational and-term), independent of clk.
REQ-033 Reset asserted mid-job SHALL abandon the job with no done pulse; after release the block restarts in IDLE.

Verification
REQ-034 req=01, 225 contiguous beats, solver streams 5 coordinates -> gnt=01; 5 rsp_valid cycles, each 1 cycle after sol_out_valid; then done=1, stat=00, rsp_id=0.
REQ-035 req=11 from reset, two full jobs -> requester 0 served first, requester 1 second, gnt never 11.
REQ-036 req_valid dropped at beat 100 -> stat=10 done; sol_rst_n low exactly 2 cycles; sol_in_valid not asserted beyond beat 100.
REQ-037 Solver silent after load -> ABORT after 3000 WAIT cycles, done with stat=11.
REQ-038 sol_not_valid pulse in WAIT (and a case with sol_out_valid simultaneously high) -> done, stat=01, no rsp_valid.
REQ-039 rst_n low during STREAM -> all outputs 0 within the reset assertion with no clock edge; after release a fresh req=10 is granted to requester 1 only after its request.
